// File: rtl/jtdsp16_extbridge.sv
// External-ROM fetch bridge: DSP program-ROM port to a system memory bus with bus_cs/bus_ok handshake.
// Optional JTDSP16_EXTCACHE_EN replaces the last-address hit register with a 4-entry direct-mapped cache.
module jtdsp16_extbridge #(
    parameter int unsigned TOUT      = 255,
    parameter logic [15:0] TOUT_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph1,
    input  logic        ext_rq,
    input  logic [15:0] ext_addr,
    output logic [15:0] ext_data,
    output logic        ext_wait,
    input  logic        flush,
    output logic        bus_cs,
    output logic [15:0] bus_addr,
    input  logic        bus_ok,
    input  logic [15:0] bus_data,
    output logic        tout_err
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TOUT_LAST = CW'(TOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic          flush_pend;
    logic          req;
    logic          hit;
    logic          miss;
    logic          done_ok;
    logic          done_to;

    assign req = ph1 & ext_rq & (ext_addr[15:12] != 4'd0);

`ifdef JTDSP16_EXTCACHE_EN
    logic [13:0] ctag  [4];
    logic [15:0] cdata [4];
    logic [3:0]  cvalid;
    logic [1:0]  ridx;
    logic [1:0]  fidx;

    assign ridx = ext_addr[1:0];
    assign fidx = bus_addr[1:0];
    assign hit  = req & cvalid[ridx] & (ctag[ridx] == ext_addr[15:2]);
`else
    logic [15:0] last_addr;
    logic        last_valid;

    assign hit = req & last_valid & (ext_addr == last_addr);
`endif

    assign miss     = req & ~hit;
    assign done_ok  = (state == WAIT) & bus_ok;
    assign done_to  = (state == WAIT) & ~bus_ok & (cnt == TOUT_LAST);
    // Stall starts combinationally with the miss; reset forces it low.
    assign ext_wait = rst & (((state == IDLE) & miss) | (state != IDLE));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (miss) state_nx = WAIT;
            WAIT:    if (done_ok || done_to) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus handshake, timeout counter and returned word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_data   <= 16'd0;
            bus_cs     <= 1'b0;
            bus_addr   <= 16'd0;
            tout_err   <= 1'b0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            tout_err <= 1'b0;
            if (state == IDLE) begin
                if (miss) begin
                    bus_addr   <= ext_addr;
                    bus_cs     <= 1'b1;
                    cnt        <= '0;
                    flush_pend <= flush;
                end
`ifdef JTDSP16_EXTCACHE_EN
                if (hit) ext_data <= cdata[ridx];
`endif
            end
            if (state == WAIT) begin
                if (flush) flush_pend <= 1'b1;
                if (bus_ok) begin
                    ext_data <= bus_data;
                    bus_cs   <= 1'b0;
                end else if (cnt == TOUT_LAST) begin
                    ext_data <= TOUT_DATA;
                    bus_cs   <= 1'b0;
                    tout_err <= 1'b1;
                end else if (cnt != {CW{1'b1}}) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef JTDSP16_EXTCACHE_EN
    // Cache fill/invalidate; a flush seen during the fetch keeps the filled entry invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cvalid <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                ctag[i]  <= 14'd0;
                cdata[i] <= 16'd0;
            end
        end else begin
            if (flush) cvalid <= 4'd0;
            if (done_ok) begin
                ctag[fidx]   <= bus_addr[15:2];
                cdata[fidx]  <= bus_data;
                cvalid[fidx] <= ~(flush | flush_pend);
            end else if (done_to) begin
                cvalid[fidx] <= 1'b0;
            end
        end
    end
`else
    // Last-address hit register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr  <= 16'd0;
            last_valid <= 1'b0;
        end else begin
            if (done_ok) begin
                last_addr  <= bus_addr;
                last_valid <= ~(flush | flush_pend);
            end else if (done_to || flush) begin
                last_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
